// File: rtl/step_pkg.sv
// Shared stepper definitions: half-step coil table, idle pattern, phase type, direction codes.
// Used by the decoder here and by the coil driver.
package step_pkg;

  typedef logic [2:0] phase_t;

  localparam logic [3:0] COIL_IDLE = 4'b0000;

  // Entry i is the coil pattern for half-step phase i (bit 3 = coil A).
  // Full-step drive uses only the odd or only the even entries.
  localparam logic [7:0][3:0] HALF_STEP_TBL = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/step_phase_lut.sv
// Combinational coil-pattern to half-step phase decode; valid only for the 8 table patterns.
// Non-table patterns (including idle) report phase 0 with valid low.
module step_phase_lut
  import step_pkg::*;
(
  input  logic [3:0] coils,
  output logic [2:0] phase,
  output logic       valid
);

  always_comb begin
    phase = '0;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (coils == HALF_STEP_TBL[i]) begin
        phase = phase_t'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_decoder.sv
// Stepper coil-bus monitor: recovers phase, steps, direction and signed position; flags skips and illegal patterns.
// Optional stall detector enabled by defining STEP_DECODE_STALL_EN.
module step_decoder
  import step_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic [3:0]       coils,
  input  logic             pos_clr,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             energised,
  output logic             err_skip,
  output logic             err_illegal,
  output logic             stall
);

  logic [3:0]       coil_q;
  phase_t           prev_phase_q, prev_phase_d;
  logic             ref_valid_q, ref_valid_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             step_dir_q, step_dir_d;
  logic             step_pulse_q, step_pulse_d;
  logic             err_skip_q, err_skip_d;
  logic             err_illegal_q, err_illegal_d;
  logic             illegal_q, illegal_d;

  phase_t           lut_phase;
  logic             lut_valid;
  logic             idle;
  logic             illegal;
  phase_t           delta;
  logic             fwd;
  logic             rev;
  logic             step_acc;
  logic             skip_acc;
  logic [POS_W-1:0] step_amt;

  step_phase_lut u_lut (
    .coils (coil_q),
    .phase (lut_phase),
    .valid (lut_valid)
  );

  assign idle    = (coil_q == COIL_IDLE);
  assign illegal = !idle && !lut_valid;
  assign delta   = phase_t'(lut_phase - prev_phase_q);
  assign fwd     = (delta == 3'd1) || (delta == 3'd2);
  assign rev     = (delta == 3'd6) || (delta == 3'd7);

  assign step_acc = lut_valid && ref_valid_q && (fwd || rev);
  assign skip_acc = lut_valid && ref_valid_q && !fwd && !rev && (delta != 3'd0);

  // Reading delta as a 3-bit signed value gives +1/+2 forward and -1/-2 reverse.
  assign step_amt = {{(POS_W-3){delta[2]}}, delta};

  always_comb begin
    ref_valid_d   = lut_valid;
    prev_phase_d  = lut_valid ? lut_phase : prev_phase_q;
    position_d    = position_q;
    step_dir_d    = step_dir_q;
    step_pulse_d  = step_acc;
    err_skip_d    = skip_acc;
    illegal_d     = illegal;
    err_illegal_d = illegal && !illegal_q;
    if (step_acc) begin
      position_d = position_q + step_amt;
      step_dir_d = fwd ? DIR_FWD : DIR_REV;
    end
    if (pos_clr) begin
      position_d = '0;
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      coil_q        <= COIL_IDLE;
      prev_phase_q  <= '0;
      ref_valid_q   <= 1'b0;
      position_q    <= '0;
      step_dir_q    <= DIR_FWD;
      step_pulse_q  <= 1'b0;
      err_skip_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      coil_q        <= coils;
      prev_phase_q  <= prev_phase_d;
      ref_valid_q   <= ref_valid_d;
      position_q    <= position_d;
      step_dir_q    <= step_dir_d;
      step_pulse_q  <= step_pulse_d;
      err_skip_q    <= err_skip_d;
      err_illegal_q <= err_illegal_d;
      illegal_q     <= illegal_d;
    end
  end

`ifdef STEP_DECODE_STALL_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Cleared on the same edge that raises step_pulse, so stall drops with the pulse.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (idle || step_acc) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall = (stall_cnt_q == STALL_MAX);
`else
  assign stall = 1'b0;
`endif

  assign position    = position_q;
  assign step_pulse  = step_pulse_q;
  assign step_dir    = step_dir_q;
  assign phase       = lut_phase;
  assign phase_valid = lut_valid;
  assign energised   = !idle;
  assign err_skip    = err_skip_q;
  assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_step_decoder.sv
// Scoreboard bench for step_decoder: directed coil vectors push expected events; a monitor checks each pulse.
module tb_step_decoder;

  typedef struct packed {
    logic        stp;
    logic        skp;
    logic        ill;
    logic        dir;
    logic [15:0] pos;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  coils;
  logic        pos_clr;
  logic [15:0] position;
  logic        step_pulse, step_dir, phase_valid, energised, err_skip, err_illegal, stall;
  logic [2:0]  phase;

  ev_t         q[$];
  int          errs = 0;
  int          checks = 0;
  logic [3:0]  tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

  step_decoder #(.POS_W(16), .STALL_CYCLES(10)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .coils          (coils),
    .pos_clr        (pos_clr),
    .position       (position),
    .step_pulse     (step_pulse),
    .step_dir       (step_dir),
    .phase          (phase),
    .phase_valid    (phase_valid),
    .energised      (energised),
    .err_skip       (err_skip),
    .err_illegal    (err_illegal),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] c, input logic clr);
    coils   = c;
    pos_clr = clr;
    @(posedge clk);
    #1;
    pos_clr = 1'b0;
  endtask

  // Apply one coil vector; if an event is expected from it, queue it first.
  task automatic vec(input logic [3:0] c, input logic s, input logic k, input logic i,
                     input logic dir, input logic [15:0] pos);
    if (s || k || i) q.push_back('{s, k, i, dir, pos});
    cyc(c, 1'b0);
  endtask

  task automatic none(input logic [3:0] c);
    cyc(c, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && (step_pulse || err_skip || err_illegal)) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_event: step=%0b skip=%0b illegal=%0b pos=%0h, expected no event",
                 step_pulse, err_skip, err_illegal, position);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_kind", {29'd0, step_pulse, err_skip, err_illegal}, {29'd0, e.stp, e.skp, e.ill});
        chk("ev_dir", {31'd0, step_dir}, {31'd0, e.dir});
        chk("ev_pos", {16'd0, position}, {16'd0, e.pos});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ep;
    int          ph;
    rst = 1'b1; coils = 4'b0000; pos_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_position", {16'd0, position}, 32'd0);
    chk("rst_dir", {31'd0, step_dir}, 32'd1);
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_phase_valid", {31'd0, phase_valid}, 32'd0);
    chk("rst_energised", {31'd0, energised}, 32'd0);
    chk("rst_pulses", {29'd0, step_pulse, err_skip, err_illegal}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Forward half-steps from a fresh reference.
    none(4'b1000);
    vec(4'b1100, 1, 0, 0, 1, 16'h0001);
    vec(4'b0100, 1, 0, 0, 1, 16'h0002);
    vec(4'b0110, 1, 0, 0, 1, 16'h0003);
    none(4'b0110);
    none(4'b0110);
    chk("fwd_position", {16'd0, position}, 32'd3);
    chk("fwd_dir", {31'd0, step_dir}, 32'd1);

    // Reset mid-operation with coils energised.
    #2 rst = 1'b1;
    #2;
    chk("midrst_position", {16'd0, position}, 32'd0);
    chk("midrst_energised", {31'd0, energised}, 32'd0);
    coils = 4'b1000;
    @(posedge clk);
    #1 rst = 1'b0;

    // Reverse half-steps.
    none(4'b1000);
    vec(4'b1001, 1, 0, 0, 0, 16'hFFFF);
    vec(4'b0001, 1, 0, 0, 0, 16'hFFFE);
    vec(4'b0011, 1, 0, 0, 0, 16'hFFFD);
    none(4'b0000);
    cyc(4'b0000, 1'b1);
    chk("clr_position", {16'd0, position}, 32'd0);
    chk("clr_keeps_dir", {31'd0, step_dir}, 32'd0);

    // Full-step sequence, then a 4-phase jump.
    none(4'b1100);
    vec(4'b0110, 1, 0, 0, 1, 16'h0002);
    vec(4'b0011, 1, 0, 0, 1, 16'h0004);
    vec(4'b1001, 1, 0, 0, 1, 16'h0006);
    vec(4'b1100, 1, 0, 0, 1, 16'h0008);
    vec(4'b0011, 0, 1, 0, 1, 16'h0008);
    none(4'b0000);

    // Illegal patterns: pulse only on entry, reference lost.
    vec(4'b1010, 0, 0, 1, 1, 16'h0008);
    repeat (4) none(4'b1010);
    none(4'b0100);
    vec(4'b0110, 1, 0, 0, 1, 16'h0009);
    vec(4'b1111, 0, 0, 1, 1, 16'h0009);
    none(4'b1010);
    none(4'b0110);
    vec(4'b0100, 1, 0, 0, 0, 16'h0008);
    none(4'b0000);

    // Combinational phase decode of the registered pattern.
    none(4'b0011);
    chk("dec_phase", {29'd0, phase}, 32'd5);
    chk("dec_valid", {31'd0, phase_valid}, 32'd1);
    chk("dec_energised", {31'd0, energised}, 32'd1);
    vec(4'b1010, 0, 0, 1, 0, 16'h0008);
    chk("dec_illegal_valid", {31'd0, phase_valid}, 32'd0);
    chk("dec_illegal_energised", {31'd0, energised}, 32'd1);
    none(4'b0000);
    chk("dec_idle_energised", {31'd0, energised}, 32'd0);
`ifndef STEP_DECODE_STALL_EN
    chk("stall_tied_low", {31'd0, stall}, 32'd0);
`endif

    // Drive position up to 0x7FFF, then wrap both ways.
    cyc(4'b0000, 1'b1);
    none(4'b1000);
    ph = 0;
    ep = 16'h0000;
    for (int i = 0; i < 16383; i++) begin
      ph = (ph + 2) % 8;
      ep = ep + 16'd2;
      vec(tbl[ph], 1, 0, 0, 1, ep);
    end
    ph = (ph + 1) % 8;
    vec(tbl[ph], 1, 0, 0, 1, 16'h7FFF);
    ph = (ph + 1) % 8;
    vec(tbl[ph], 1, 0, 0, 1, 16'h8000);
    ph = (ph + 7) % 8;
    vec(tbl[ph], 1, 0, 0, 0, 16'h7FFF);
    ph = (ph + 1) % 8;
    vec(tbl[ph], 1, 0, 0, 1, 16'h8000);
    ph = (ph + 1) % 8;
    q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    cyc(tbl[ph], 1'b0);
    cyc(tbl[ph], 1'b1);
    none(4'b0000);
    none(4'b0000);
    chk("wrap_clr_position", {16'd0, position}, 32'd0);

`ifdef STEP_DECODE_STALL_EN
    // Hold an energised pattern without stepping.
    none(4'b1100);
    chk("stall_cycle1", {31'd0, stall}, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      none(4'b1100);
      chk($sformatf("stall_cycle%0d", k + 1), {31'd0, stall}, (k >= 10) ? 32'd1 : 32'd0);
    end
    vec(4'b0110, 1, 0, 0, 1, 16'h0002);
    chk("stall_before_step", {31'd0, stall}, 32'd1);
    none(4'b0110);
    chk("stall_after_step", {31'd0, stall}, 32'd0);
    none(4'b0000);
    none(4'b0000);
    chk("stall_idle", {31'd0, stall}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
